// File: rtl/store_unit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : store_unit_pkg
//  Purpose  : Shared types for the store unit: machine word width and the
//             memory-operation size encoding carried on st_op.
//  Revision : 1.0  initial release
// ============================================================================
package store_unit_pkg;

    localparam int XLEN = 32;

    // Encoding 2'd3 is deliberately unnamed; the store unit treats it as an
    // illegal size and raises the misaligned exception.
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_op_e;

endpackage
`default_nettype wire

// File: rtl/store_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : store_unit_if
//  Purpose  : Bundles the store-request, memory-write and load-hazard signals
//             of the store unit.
//  Ports    : st_valid/st_ready/st_addr/st_wdata/st_op  store request (MEM stage)
//             misaligned                                 exception pulse
//             mem_req/mem_gnt/mem_addr/mem_wdata/mem_wstrb  data-memory write
//             ld_addr/ld_hazard                          load-vs-store hazard
//             empty                                      buffer drained
//  Modports : slave  - the store unit itself
//             master - the pipeline / memory side driving it
//  Revision : 1.0  initial release
// ============================================================================
interface store_unit_if;
    import store_unit_pkg::*;

    logic            st_valid;
    logic            st_ready;
    logic [XLEN-1:0] st_addr;
    logic [XLEN-1:0] st_wdata;
    mem_op_e         st_op;
    logic            misaligned;
    logic            mem_req;
    logic            mem_gnt;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic [XLEN-1:0] ld_addr;
    logic            ld_hazard;
    logic            empty;

    modport slave (
        input  st_valid, st_addr, st_wdata, st_op, mem_gnt, ld_addr,
        output st_ready, misaligned, mem_req, mem_addr, mem_wdata, mem_wstrb,
               ld_hazard, empty
    );

    modport master (
        output st_valid, st_addr, st_wdata, st_op, mem_gnt, ld_addr,
        input  st_ready, misaligned, mem_req, mem_addr, mem_wdata, mem_wstrb,
               ld_hazard, empty
    );

endinterface
`default_nettype wire

// File: rtl/store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : store_unit
//  Purpose  : Store buffer between the MEM stage and data memory. Accepts
//             byte/half/word stores, flags misaligned ones, lane-aligns the
//             data into a word-wide write with byte strobes, queues entries in
//             a FIFO and drains them to memory in order via a req/gnt
//             handshake. Also reports whether the load in MEM hits any word
//             still waiting in the buffer.
//  Ports    : clk    - single clock, rising edge
//             rst_n  - asynchronous active-low reset
//             bus    - store_unit_if.slave (request, memory, hazard, empty)
//  Params   : DEPTH  - number of buffer entries (power of two, >= 2)
//  Revision : 1.0  initial release
// ============================================================================
module store_unit #(
    parameter int DEPTH = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    store_unit_if.slave   bus
);
    import store_unit_pkg::*;

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [DEPTH-1:0] valid_q,  valid_d;
    logic             misaligned_q, misaligned_d;

    // Entry payload. Only the word address is kept; the byte offset is
    // already folded into the strobes.
    logic [XLEN-3:0]  addr_q [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [3:0]       strb_q [DEPTH];

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic             buf_empty;
    logic             buf_ready;
    logic             accept;
    logic             push;
    logic             pop;
    logic             st_mis;
    logic [1:0]       off;
    logic [XLEN-1:0]  lane_wdata;
    logic [3:0]       lane_wstrb;
    logic [DEPTH-1:0] hit;
    logic             unused_ld_offset;

    assign buf_empty = (count_q == '0);
    // No bypass: a pop in the same cycle does not make room for a push.
    assign buf_ready = (count_q < DEPTH_C);
    assign accept    = bus.st_valid && buf_ready;
    assign push      = accept && !st_mis;
    // mem_gnt only matters while a write is actually being presented.
    assign pop       = !buf_empty && bus.mem_gnt;

    // Hazard matching is on word address, so the load byte offset is not needed.
    assign unused_ld_offset = ^bus.ld_addr[1:0];

    // Size check and lane alignment of the incoming store.
    always_comb begin
        off        = bus.st_addr[1:0];
        lane_wdata = bus.st_wdata;
        lane_wstrb = 4'b0000;
        st_mis     = 1'b1;
        case (bus.st_op)
            MEM_BYTE: begin
                lane_wdata = {4{bus.st_wdata[7:0]}};
                lane_wstrb = 4'b0001 << off;
                st_mis     = 1'b0;
            end
            MEM_HALF: begin
                lane_wdata = {2{bus.st_wdata[15:0]}};
                lane_wstrb = off[1] ? 4'b1100 : 4'b0011;
                st_mis     = off[0];
            end
            MEM_WORD: begin
                lane_wdata = bus.st_wdata;
                lane_wstrb = 4'b1111;
                st_mis     = |off;
            end
            default: begin
                st_mis     = 1'b1;
            end
        endcase
    end

    // Next-state for pointers, occupancy and the exception pulse.
    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        count_d      = count_q;
        valid_d      = valid_q;
        misaligned_d = accept && st_mis;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Push never targets the head slot being popped: a push with a pop
        // implies at least one free slot, so the indices differ.
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Payload storage carries no reset: every consumer is qualified by the
    // valid bits or by the buffer being non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= bus.st_addr[XLEN-1:2];
            data_q[wr_ptr_q] <= lane_wdata;
            strb_q[wr_ptr_q] <= lane_wstrb;
        end
    end

    // ------------------------------------------------------------------
    // Load hazard: any live entry whose word address matches the load.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < DEPTH; i++) begin : g_hazard
        assign hit[i] = valid_q[i] && (addr_q[i] == bus.ld_addr[XLEN-1:2]);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.st_ready   = buf_ready;
    assign bus.misaligned = misaligned_q;
    assign bus.empty      = buf_empty;
    assign bus.mem_req    = !buf_empty;
    assign bus.ld_hazard  = |hit;

    // Head entry, forced to zero when nothing is buffered so that reset
    // (which clears the count) also clears the write bus.
    assign bus.mem_addr   = buf_empty ? '0 : {addr_q[rd_ptr_q], 2'b00};
    assign bus.mem_wdata  = buf_empty ? '0 : data_q[rd_ptr_q];
    assign bus.mem_wstrb  = buf_empty ? '0 : strb_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_store_unit
//  Purpose  : Self-checking bench for store_unit: directed scenarios plus a
//             randomized run compared against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_store_unit;
    import store_unit_pkg::*;

    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    store_unit_if bus();

    store_unit #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    // ---------------- reference model helpers ----------------
    function automatic bit model_mis(input logic [31:0] a, input int op);
        if (op == 0)      return 1'b0;
        else if (op == 1) return (a % 2) != 0;
        else if (op == 2) return (a % 4) != 0;
        else              return 1'b1;
    endfunction

    function automatic ent_t model_lane(input logic [31:0] a, input logic [31:0] d, input int op);
        ent_t e;
        int   o;
        o      = int'(a % 4);
        e.addr = a - 32'(o);
        if (op == 0) begin
            e.data = (d & 32'h0000_00FF) * 32'h0101_0101;
            e.strb = 4'(1 << o);
        end else if (op == 1) begin
            e.data = (d & 32'h0000_FFFF) * 32'h0001_0001;
            e.strb = (o >= 2) ? 4'hC : 4'h3;
        end else begin
            e.data = d;
            e.strb = 4'hF;
        end
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input int op);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_wdata = d;
        bus.st_op    = mem_op_e'(op[1:0]);
    endtask

    task automatic idle_store();
        bus.st_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        total_cnt++; if (bus.st_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.st_ready); else pass_cnt++;
        total_cnt++; if (bus.empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", bus.empty); else pass_cnt++;
        total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.mem_req); else pass_cnt++;
        total_cnt++; if (bus.misaligned !== 1'b0) $display("FAIL rst_mis: got %b want 0", bus.misaligned); else pass_cnt++;
        total_cnt++; if (bus.ld_hazard !== 1'b0) $display("FAIL rst_hz: got %b want 0", bus.ld_hazard); else pass_cnt++;
        total_cnt++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 68'h0)
            $display("FAIL rst_bus: got %h/%h/%h want 0/0/0", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_byte_store();
        drive_store(32'h1003, 32'h0000_00A5, 0);
        total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL sb_req_before: got %b want 0", bus.mem_req); else pass_cnt++;
        step();
        idle_store();
        total_cnt++; if (bus.mem_req !== 1'b1) $display("FAIL sb_req: got %b want 1", bus.mem_req); else pass_cnt++;
        total_cnt++; if (bus.mem_addr !== 32'h1000) $display("FAIL sb_addr: got %h want 00001000", bus.mem_addr); else pass_cnt++;
        total_cnt++; if (bus.mem_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata: got %h want a5a5a5a5", bus.mem_wdata); else pass_cnt++;
        total_cnt++; if (bus.mem_wstrb !== 4'b1000) $display("FAIL sb_wstrb: got %b want 1000", bus.mem_wstrb); else pass_cnt++;
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        total_cnt++; if (bus.empty !== 1'b1) $display("FAIL sb_drained: got %b want 1", bus.empty); else pass_cnt++;
    endtask

    task automatic test_half_and_misaligned();
        drive_store(32'h2002, 32'h1234_BEEF, 1);
        step();
        idle_store();
        total_cnt++; if (bus.mem_addr !== 32'h2000) $display("FAIL sh_addr: got %h want 00002000", bus.mem_addr); else pass_cnt++;
        total_cnt++; if (bus.mem_wdata !== 32'hBEEF_BEEF) $display("FAIL sh_wdata: got %h want beefbeef", bus.mem_wdata); else pass_cnt++;
        total_cnt++; if (bus.mem_wstrb !== 4'b1100) $display("FAIL sh_wstrb: got %b want 1100", bus.mem_wstrb); else pass_cnt++;
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        drive_store(32'h2001, 32'hDEAD_BEEF, 2);
        step();
        idle_store();
        total_cnt++; if (bus.misaligned !== 1'b1) $display("FAIL sw_mis_pulse: got %b want 1", bus.misaligned); else pass_cnt++;
        total_cnt++; if (bus.empty !== 1'b1) $display("FAIL sw_mis_empty: got %b want 1", bus.empty); else pass_cnt++;
        total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL sw_mis_req: got %b want 0", bus.mem_req); else pass_cnt++;
        step();
        total_cnt++; if (bus.misaligned !== 1'b0) $display("FAIL sw_mis_end: got %b want 0", bus.misaligned); else pass_cnt++;
    endtask

    task automatic test_full();
        bus.mem_gnt = 1'b0;
        drive_store(32'h5000, 32'h1111_1111, 2);
        step();
        drive_store(32'h5004, 32'h2222_2222, 2);
        total_cnt++; if (bus.st_ready !== 1'b1) $display("FAIL full_ready1: got %b want 1", bus.st_ready); else pass_cnt++;
        step();
        drive_store(32'h5008, 32'h3333_3333, 2);
        total_cnt++; if (bus.st_ready !== 1'b0) $display("FAIL full_ready0: got %b want 0", bus.st_ready); else pass_cnt++;
        step();
        idle_store();
        total_cnt++; if (bus.mem_addr !== 32'h5000 || bus.mem_wdata !== 32'h1111_1111)
            $display("FAIL full_head_a: got %h/%h want 00005000/11111111", bus.mem_addr, bus.mem_wdata); else pass_cnt++;
        step();
        total_cnt++; if (bus.mem_addr !== 32'h5000 || bus.mem_wdata !== 32'h1111_1111 || bus.mem_wstrb !== 4'hF)
            $display("FAIL full_stall_stable: got %h/%h/%h want 00005000/11111111/f", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb); else pass_cnt++;
        bus.mem_gnt = 1'b1;
        step();
        total_cnt++; if (bus.mem_addr !== 32'h5004 || bus.mem_wdata !== 32'h2222_2222)
            $display("FAIL full_head_b: got %h/%h want 00005004/22222222", bus.mem_addr, bus.mem_wdata); else pass_cnt++;
        step();
        bus.mem_gnt = 1'b0;
        total_cnt++; if (bus.empty !== 1'b1 || bus.mem_req !== 1'b0)
            $display("FAIL full_drained: got empty=%b req=%b want 1/0", bus.empty, bus.mem_req); else pass_cnt++;
    endtask

    task automatic test_hazard();
        bus.mem_gnt = 1'b0;
        drive_store(32'h3000, 32'hCAFE_F00D, 2);
        step();
        idle_store();
        bus.ld_addr = 32'h3002;
        #1;
        total_cnt++; if (bus.ld_hazard !== 1'b1) $display("FAIL hz_hit: got %b want 1", bus.ld_hazard); else pass_cnt++;
        bus.ld_addr = 32'h3004;
        #1;
        total_cnt++; if (bus.ld_hazard !== 1'b0) $display("FAIL hz_miss: got %b want 0", bus.ld_hazard); else pass_cnt++;
        bus.ld_addr = 32'h3000;
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        total_cnt++; if (bus.ld_hazard !== 1'b0) $display("FAIL hz_popped: got %b want 0", bus.ld_hazard); else pass_cnt++;
    endtask

    task automatic test_push_pop();
        bus.mem_gnt = 1'b0;
        drive_store(32'h6000, 32'hAAAA_0001, 2);
        step();
        bus.mem_gnt = 1'b1;
        drive_store(32'h6004, 32'hBBBB_0002, 2);
        total_cnt++; if (bus.st_ready !== 1'b1) $display("FAIL pp_ready: got %b want 1", bus.st_ready); else pass_cnt++;
        step();
        idle_store();
        bus.mem_gnt = 1'b0;
        total_cnt++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h6004 || bus.mem_wdata !== 32'hBBBB_0002)
            $display("FAIL pp_new_head: got req=%b %h/%h want 1 00006004/bbbb0002", bus.mem_req, bus.mem_addr, bus.mem_wdata); else pass_cnt++;
        total_cnt++; if (bus.st_ready !== 1'b1) $display("FAIL pp_count1: got ready=%b want 1", bus.st_ready); else pass_cnt++;
        drive_store(32'h6008, 32'hCCCC_0003, 2);
        step();
        idle_store();
        total_cnt++; if (bus.st_ready !== 1'b0) $display("FAIL pp_count2: got ready=%b want 0", bus.st_ready); else pass_cnt++;
        bus.mem_gnt = 1'b1;
        step();
        total_cnt++; if (bus.mem_addr !== 32'h6008) $display("FAIL pp_head_c: got %h want 00006008", bus.mem_addr); else pass_cnt++;
        step();
        bus.mem_gnt = 1'b0;
        total_cnt++; if (bus.empty !== 1'b1) $display("FAIL pp_drained: got %b want 1", bus.empty); else pass_cnt++;
    endtask

    task automatic test_reset_midstall();
        bus.mem_gnt = 1'b0;
        drive_store(32'h7000, 32'h0000_0071, 2);
        step();
        drive_store(32'h7004, 32'h0000_0072, 2);
        step();
        idle_store();
        total_cnt++; if (bus.mem_req !== 1'b1 || bus.st_ready !== 1'b0)
            $display("FAIL ms_pre: got req=%b ready=%b want 1/0", bus.mem_req, bus.st_ready); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.mem_req !== 1'b0 || bus.empty !== 1'b1)
            $display("FAIL ms_async: got req=%b empty=%b want 0/1", bus.mem_req, bus.empty); else pass_cnt++;
        total_cnt++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 68'h0 || bus.st_ready !== 1'b1)
            $display("FAIL ms_bus: got %h/%h/%h ready=%b want 0/0/0 1", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.st_ready); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL ms_no_write%0d: got %b want 0", i, bus.mem_req); else pass_cnt++;
        end
        bus.mem_gnt = 1'b0;
    endtask

    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        bit          exp_mis;
        bit          exp_hz;
        bit          v;
        bit          g;
        bit          acc;
        logic [31:0] a;
        logic [31:0] d;
        int          op;
        exp_mis = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (q.size() > 0 && ($urandom % 2) == 1)
                bus.ld_addr = q[$urandom_range(0, q.size() - 1)].addr + 32'($urandom_range(0, 3));
            else
                bus.ld_addr = 32'h4000 + 32'($urandom_range(0, 63));
            #1;
            exp_hz = 1'b0;
            foreach (q[k]) if ((q[k].addr >> 2) == (bus.ld_addr >> 2)) exp_hz = 1'b1;

            total_cnt++; if (bus.mem_req !== (q.size() > 0) || bus.empty !== (q.size() == 0))
                $display("FAIL rnd_req c%0d: got req=%b empty=%b want occupancy %0d", cyc, bus.mem_req, bus.empty, q.size()); else pass_cnt++;
            total_cnt++; if (bus.st_ready !== (q.size() < DEPTH))
                $display("FAIL rnd_ready c%0d: got %b want %b", cyc, bus.st_ready, q.size() < DEPTH); else pass_cnt++;
            total_cnt++; if (bus.misaligned !== exp_mis)
                $display("FAIL rnd_mis c%0d: got %b want %b", cyc, bus.misaligned, exp_mis); else pass_cnt++;
            total_cnt++; if (bus.ld_hazard !== exp_hz)
                $display("FAIL rnd_hz c%0d: got %b want %b (ld %h)", cyc, bus.ld_hazard, exp_hz, bus.ld_addr); else pass_cnt++;
            if (q.size() > 0) begin
                total_cnt++; if (bus.mem_addr !== q[0].addr || bus.mem_wdata !== q[0].data || bus.mem_wstrb !== q[0].strb)
                    $display("FAIL rnd_head c%0d: got %h/%h/%h want %h/%h/%h", cyc, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb,
                             q[0].addr, q[0].data, q[0].strb); else pass_cnt++;
            end

            v  = ($urandom % 3) != 0;
            a  = 32'h4000 + 32'($urandom_range(0, 63));
            d  = $urandom;
            op = $urandom_range(0, 3);
            g  = ($urandom % 2) == 1;
            if (v) drive_store(a, d, op); else idle_store();
            bus.mem_gnt = g;

            acc     = v && (q.size() < DEPTH);
            exp_mis = acc && model_mis(a, op);
            if (g && q.size() > 0) void'(q.pop_front());
            if (acc && !model_mis(a, op)) begin
                e = model_lane(a, d, op);
                q.push_back(e);
            end
            @(posedge clk);
            @(negedge clk);
        end
        idle_store();
        bus.mem_gnt = 1'b0;
    endtask

    initial begin
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_wdata = '0;
        bus.st_op    = MEM_BYTE;
        bus.mem_gnt  = 1'b0;
        bus.ld_addr  = '0;

        test_reset();
        test_byte_store();
        test_half_and_misaligned();
        test_full();
        test_hazard();
        test_push_pop();
        test_reset_midstall();
        test_random();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning store-buffer entries; legal values are powers of two, at least 2.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 The block SHALL have port st_valid, input, 1, store request from the MEM stage.
REQ-005 The block SHALL have port st_ready, output, 1, the block can accept a store.
REQ-006 The block SHALL have port st_addr, input, XLEN, store byte address.
REQ-007 The block SHALL have port st_wdata, input, XLEN, store data, right-justified (rs2).
REQ-008 The block SHALL have port st_op, input, mem_op_e, store size (MEM_BYTE, MEM_HALF or MEM_WORD).
REQ-009 The block SHALL have port misaligned, output, 1, registered one-cycle exception pulse.
REQ-010 The block SHALL have port mem_req, output, 1, write request to data memory.
REQ-011 The block SHALL have port mem_gnt, input, 1, memory accepts the current write.
REQ-012 The block SHALL have port mem_addr, output, XLEN, word-aligned write address.
REQ-013 The block SHALL have port mem_wdata, output, XLEN, lane-aligned write data.
REQ-014 The block SHALL have port mem_wstrb, output, 4, byte-lane write enables.
REQ-015 The block SHALL have port ld_addr, input, XLEN, address of the load currently in MEM.
REQ-016 The block SHALL have port ld_hazard, output, 1, a buffered store targets the word at ld_addr.
REQ-017 The block SHALL have port empty, output, 1, the store buffer holds no entries (for fence and drain).

Function
REQ-018 A store SHALL be accepted in a cycle when st_valid=1 and st_ready=1.
REQ-019 st_ready SHALL be 1 exactly when the entry count is below DEPTH, with no same-cycle pop bypass.
REQ-020 An accepted store SHALL be misaligned when it is MEM_HALF with st_addr[0]=1, MEM_WORD with st_addr[1:0]!=0, or any other st_op value.
REQ-021 A misaligned store SHALL not be enqueued, and misaligned SHALL be 1 for exactly the following cycle.
REQ-022 Lane alignment, with off=st_addr[1:0]: MEM_BYTE SHALL give wdata {4{st_wdata[7:0]}} and wstrb 4'b0001<<off.
REQ-023 Lane alignment: MEM_HALF SHALL give wdata {2{st_wdata[15:0]}}, with wstrb 4'b0011 when off[1]=0 and 4'b1100 when off[1]=1.
REQ-024 Lane alignment: MEM_WORD SHALL give wdata st_wdata and wstrb 4'b1111.
REQ-025 Each entry SHALL store {st_addr[XLEN-1:2],2'b00}, the aligned wdata and the wstrb.
REQ-026 The buffer SHALL be a FIFO with wrapping read and write pointers; pointers SHALL wrap modulo DEPTH.
REQ-027 The count SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-028 mem_req SHALL equal !empty; mem_addr, mem_wdata and mem_wstrb SHALL present the head entry.
REQ-029 Pop SHALL occur when mem_req=1 and mem_gnt=1; mem_gnt SHALL be ignored when mem_req=0.
REQ-030 While mem_req=1 and mem_gnt=0, all mem_* outputs SHALL remain stable.
REQ-031 An accepted store SHALL raise mem_req no earlier than the cycle after acceptance, giving 1-cycle minimum latency.
REQ-032 Stores SHALL reach memory in acceptance order.
REQ-033 ld_hazard SHALL be combinational: 1 when any valid entry's address[XLEN-1:2] equals ld_addr[XLEN-1:2].
REQ-034 ld_hazard SHALL include the head entry while it awaits mem_gnt, and SHALL exclude popped entries.
REQ-035 When full with push and pop in the same cycle, the push SHALL be rejected because st_ready=0.

Reset
REQ-036 On rst_n=0 the block SHALL asynchronously reset count and pointers to 0, mem_req=0, misaligned=0, st_ready=1, empty=1 and ld_hazard=0.
REQ-037 While reset is asserted, mem_wdata, mem_addr and mem_wstrb SHALL be 0.
REQ-038 Reset during a pending write SHALL discard all buffered stores, and mem_req SHALL drop immediately.

Verification
REQ-039 Bench SHALL cover: SB of 0x000000A5 at addr 0x1003 -> one cycle later mem_req=1, mem_addr=0x1000, mem_wdata=0xA5A5A5A5, mem_wstrb=4'b1000.
REQ-040 Bench SHALL cover: SH of 0x1234BEEF at addr 0x2002 -> mem_wdata=0xBEEFBEEF, wstrb=4'b1100; SW at 0x2001 -> misaligned pulse, empty stays 1.
REQ-041 Bench SHALL cover: DEPTH=2, mem_gnt=0, three back-to-back stores -> two accepted, st_ready=0 on the third; raising mem_gnt drains in order.
REQ-042 Bench SHALL cover: SW at 0x3000 buffered with gnt held low, ld_addr=0x3002 -> ld_hazard=1; ld_addr=0x3004 -> ld_hazard=0.
REQ-043 Bench SHALL cover: one entry buffered, push and pop in the same cycle -> count stays 1 and the new entry is presented next.
REQ-044 Bench SHALL cover: rst_n low mid-stall with two entries buffered -> mem_req=0 and empty=1 asynchronously, with no write after release.
